// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 mouse packet path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B1 = 2'd0,
        WAIT_B2 = 2'd1,
        WAIT_B3 = 2'd2
    } ps2_state_t;

    // Byte-1 bit positions
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    localparam logic [8:0] SAT_POS = 9'h0FF;
    localparam logic [8:0] SAT_NEG = 9'h100;

    // On overflow the magnitude byte is meaningless, so clamp toward the sign.
    function automatic logic [8:0] sat_delta(input logic sign,
                                             input logic ovf,
                                             input logic [7:0] mag);
        logic [8:0] d;
        if (ovf)
            d = sign ? SAT_NEG : SAT_POS;
        else
            d = {sign, mag};
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_pkt_timeout.sv
// ============================================================================
// Module      : ps2_pkt_timeout
// Description : Inter-byte idle counter; flags expiry at TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_pkt_timeout #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] c_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_count;

    assign expired = enable && (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            r_count <= '0;
        else if (enable && !expired)
            r_count <= r_count + TO_W'(1);
    end

endmodule

`default_nettype wire

// File: rtl/ps2_packet_framer.sv
// ============================================================================
// Module      : ps2_packet_framer
// Description : Frames PS/2 bytes into 3-byte mouse packets with sync check,
//               inter-byte timeout and saturated 9-bit deltas.
//               Define PS2_PKT_STATS_EN to build the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_packet_framer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stream_en,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        pkt_valid,
    output logic [7:0]  pkt_byte_1,
    output logic [7:0]  pkt_byte_2,
    output logic [7:0]  pkt_byte_3,
    output logic [2:0]  pkt_btn,
    output logic [8:0]  pkt_dx,
    output logic [8:0]  pkt_dy,
    output logic [1:0]  pkt_ovf,
    output logic        sync_err,
    output logic        timeout_err,
    output logic [7:0]  sync_err_cnt,
    output logic [7:0]  timeout_cnt,
    output logic [15:0] pkt_cnt
);

    ps2_state_t r_state, w_next;
    logic [7:0] r_b1, r_b2;
    logic       w_cap1, w_cap2, w_pkt, w_sync, w_to, w_accept, w_expired;
    logic       w_to_clear, w_to_en;

    assign w_to_en    = stream_en && (r_state != WAIT_B1);
    assign w_to_clear = !stream_en || (r_state == WAIT_B1) || w_accept || w_to;

    ps2_pkt_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_to_clear),
        .enable  (w_to_en),
        .expired (w_expired)
    );

    always_comb begin
        w_next   = r_state;
        w_cap1   = 1'b0;
        w_cap2   = 1'b0;
        w_pkt    = 1'b0;
        w_sync   = 1'b0;
        w_to     = 1'b0;
        w_accept = 1'b0;
        if (!stream_en) begin
            w_next = WAIT_B1;
        end else begin
            case (r_state)
                WAIT_B1: begin
                    if (rx_valid) begin
                        if (rx_data[SYNC]) begin
                            w_cap1   = 1'b1;
                            w_accept = 1'b1;
                            w_next   = WAIT_B2;
                        end else begin
                            w_sync = 1'b1;
                        end
                    end
                end
                WAIT_B2: begin
                    // A byte arriving on the expiry cycle takes priority.
                    if (rx_valid) begin
                        w_cap2   = 1'b1;
                        w_accept = 1'b1;
                        w_next   = WAIT_B3;
                    end else if (w_expired) begin
                        w_to   = 1'b1;
                        w_next = WAIT_B1;
                    end
                end
                WAIT_B3: begin
                    if (rx_valid) begin
                        w_pkt    = 1'b1;
                        w_accept = 1'b1;
                        w_next   = WAIT_B1;
                    end else if (w_expired) begin
                        w_to   = 1'b1;
                        w_next = WAIT_B1;
                    end
                end
                default: w_next = WAIT_B1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= WAIT_B1;
            r_b1        <= '0;
            r_b2        <= '0;
            pkt_valid   <= 1'b0;
            pkt_byte_1  <= '0;
            pkt_byte_2  <= '0;
            pkt_byte_3  <= '0;
            pkt_btn     <= '0;
            pkt_dx      <= '0;
            pkt_dy      <= '0;
            pkt_ovf     <= '0;
            sync_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            pkt_valid   <= w_pkt;
            sync_err    <= w_sync;
            timeout_err <= w_to;
            if (w_cap1) r_b1 <= rx_data;
            if (w_cap2) r_b2 <= rx_data;
            if (w_pkt) begin
                pkt_byte_1 <= r_b1;
                pkt_byte_2 <= r_b2;
                pkt_byte_3 <= rx_data;
                pkt_btn    <= r_b1[2:0];
                pkt_ovf    <= {r_b1[YOVF], r_b1[XOVF]};
                pkt_dx     <= sat_delta(r_b1[XSIGN], r_b1[XOVF], r_b2);
                pkt_dy     <= sat_delta(r_b1[YSIGN], r_b1[YOVF], rx_data);
            end
        end
    end

`ifdef PS2_PKT_STATS_EN
    logic [7:0]  r_sync_cnt, r_to_cnt;
    logic [15:0] r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_cnt <= '0;
            r_to_cnt   <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_sync && (r_sync_cnt != 8'hFF))   r_sync_cnt <= r_sync_cnt + 8'd1;
            if (w_to   && (r_to_cnt   != 8'hFF))   r_to_cnt   <= r_to_cnt + 8'd1;
            if (w_pkt  && (r_pkt_cnt  != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign sync_err_cnt = r_sync_cnt;
    assign timeout_cnt  = r_to_cnt;
    assign pkt_cnt      = r_pkt_cnt;
`else
    assign sync_err_cnt = '0;
    assign timeout_cnt  = '0;
    assign pkt_cnt      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_packet_framer.sv
// ============================================================================
// Module      : tb_ps2_packet_framer
// Description : Directed self-checking bench for ps2_packet_framer
//               (statistics expectations follow PS2_PKT_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_packet_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stream_en;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        pkt_valid;
    logic [7:0]  pkt_byte_1, pkt_byte_2, pkt_byte_3;
    logic [2:0]  pkt_btn;
    logic [8:0]  pkt_dx, pkt_dy;
    logic [1:0]  pkt_ovf;
    logic        sync_err, timeout_err;
    logic [7:0]  sync_err_cnt, timeout_cnt;
    logic [15:0] pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ps2_packet_framer #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stream_en    (stream_en),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .pkt_valid    (pkt_valid),
        .pkt_byte_1   (pkt_byte_1),
        .pkt_byte_2   (pkt_byte_2),
        .pkt_byte_3   (pkt_byte_3),
        .pkt_btn      (pkt_btn),
        .pkt_dx       (pkt_dx),
        .pkt_dy       (pkt_dy),
        .pkt_ovf      (pkt_ovf),
        .sync_err     (sync_err),
        .timeout_err  (timeout_err),
        .sync_err_cnt (sync_err_cnt),
        .timeout_cnt  (timeout_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; byte is sampled at the next posedge and the
    // task returns at the following negedge, where registered outputs are visible.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_pkt(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [2:0] btn,
                           input logic [8:0] dx, input logic [8:0] dy, input logic [1:0] ovf);
        chk({tag, "_valid"}, pkt_valid, 1);
        chk({tag, "_bytes"}, {pkt_byte_1, pkt_byte_2, pkt_byte_3}, {b1, b2, b3});
        chk({tag, "_btn"},   pkt_btn, btn);
        chk({tag, "_dx"},    pkt_dx, dx);
        chk({tag, "_dy"},    pkt_dy, dy);
        chk({tag, "_ovf"},   pkt_ovf, ovf);
    endtask

    int exp_pkts = 0;

    initial begin
        rst_n     = 1'b0;
        stream_en = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_dx_dy", {pkt_dx, pkt_dy}, 0);
        chk("rst_bytes", {pkt_byte_1, pkt_byte_2, pkt_byte_3}, 0);
        chk("rst_errs", {sync_err, timeout_err}, 0);
        chk("rst_cnts", {sync_err_cnt, timeout_cnt, pkt_cnt}, 0);
        rst_n     = 1'b1;
        stream_en = 1'b1;
        idle(2);

        // Back-to-back packet: left button, dx=+5, dy=-5
        send(8'h29);
        chk("t1_no_early_valid", pkt_valid, 0);
        send(8'h05);
        chk("t1_no_early_valid2", pkt_valid, 0);
        send(8'hFB);
        chk_pkt("t1", 8'h29, 8'h05, 8'hFB, 3'b001, 9'h005, 9'h1FB, 2'b00);
        exp_pkts++;
        idle(1);
        chk("t1_valid_pulse", pkt_valid, 0);
        chk("t1_hold_dx", pkt_dx, 9'h005);

        // Sync rejection then clean packet
        send(8'h02);
        chk("t2_sync_err", sync_err, 1);
        send(8'h08);
        chk("t2_sync_once", sync_err, 0);
        send(8'h10);
        send(8'h20);
        chk_pkt("t2", 8'h08, 8'h10, 8'h20, 3'b000, 9'h010, 9'h020, 2'b00);
        exp_pkts++;
        idle(1);

        // X overflow negative -> -256
        send(8'h58); send(8'h00); send(8'h00);
        chk_pkt("t3", 8'h58, 8'h00, 8'h00, 3'b000, 9'h100, 9'h000, 2'b01);
        exp_pkts++;
        idle(1);

        // Y overflow positive -> +255, middle button
        send(8'h8C); send(8'h7F); send(8'h12);
        chk_pkt("t4", 8'h8C, 8'h7F, 8'h12, 3'b100, 9'h07F, 9'h0FF, 2'b10);
        exp_pkts++;
        idle(1);

        // Timeout after 16 idle cycles
        send(8'h08); send(8'h01);
        idle(15);
        chk("t5_no_early_timeout", timeout_err, 0);
        idle(1);
        chk("t5_timeout_err", timeout_err, 1);
        chk("t5_no_pkt", pkt_valid, 0);
        idle(1);
        chk("t5_timeout_pulse", timeout_err, 0);
        send(8'h08); send(8'h00); send(8'h00);
        chk_pkt("t5_reframe", 8'h08, 8'h00, 8'h00, 3'b000, 9'h000, 9'h000, 2'b00);
        exp_pkts++;
        idle(1);

        // Byte on the expiry cycle wins over timeout
        send(8'h0A); send(8'h01);
        idle(15);
        send(8'h07);
        chk("t6_no_timeout", timeout_err, 0);
        chk_pkt("t6", 8'h0A, 8'h01, 8'h07, 3'b010, 9'h001, 9'h007, 2'b00);
        exp_pkts++;
        idle(1);
        chk("t6_no_late_timeout", timeout_err, 0);

        // stream_en drop mid-packet; same-cycle byte ignored
        send(8'h08); send(8'h11);
        stream_en = 1'b0;
        send(8'h22);
        chk("t7_quiet", {pkt_valid, sync_err, timeout_err}, 0);
        idle(20);
        chk("t7_no_timeout", timeout_err, 0);
        stream_en = 1'b1;
        idle(1);
        send(8'h18); send(8'h03); send(8'h04);
        chk_pkt("t7", 8'h18, 8'h03, 8'h04, 3'b000, 9'h103, 9'h004, 2'b00);
        exp_pkts++;
        idle(1);

        // 300 rejected bytes
        for (int i = 0; i < 300; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h00;
            @(negedge clk);
        end
        idle(2);
        chk("t8_no_pkt", pkt_valid, 0);
`ifdef PS2_PKT_STATS_EN
        chk("stats_sync_sat", sync_err_cnt, 8'hFF);
        chk("stats_timeout", timeout_cnt, 8'd1);
        chk("stats_pkt", pkt_cnt, exp_pkts);
`else
        chk("stats_sync_off", sync_err_cnt, 0);
        chk("stats_timeout_off", timeout_cnt, 0);
        chk("stats_pkt_off", pkt_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
